// File: rtl/pfb_pkg.sv
// Shared types and defaults for the polyphase filter bank commutator.
package pfb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REPLAY = 2'd2
    } pfb_state_t;

    localparam int DEF_FFT_LEN = 64;
    localparam int DEF_DEC_FAC = 48;
    localparam int DEF_WIDTH   = 16;

    // One modulo-P step of the phase-rotation offset (reference form).
    function automatic int unsigned ofs_step(input int unsigned ofs,
                                             input int unsigned step,
                                             input int unsigned p);
        int unsigned s;
        s = ofs + step;
        return (s >= p) ? s - p : s;
    endfunction

endpackage

// File: rtl/pfb_mod_acc.sv
// Modulo-MOD accumulator: acc <- (acc + step) mod MOD on en, cleared by clr.
// step must be below MOD, so one conditional subtract replaces a divider.
module pfb_mod_acc #(
    parameter int W   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] step,
    output logic [W-1:0] acc
);

    localparam logic [W:0] MODV = (W+1)'(MOD);

    logic [W:0] sum;
    assign sum = {1'b0, acc} + {1'b0, step};

    // Accumulate with wrap; one extra bit on the sum catches the overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= (sum >= MODV) ? W'(sum - MODV) : sum[W-1:0];
    end

endmodule

// File: rtl/pfb_commutator_seq.sv
// Commutator sequencer: per frame admits DEC_FAC samples into the branch
// delay lines, then replays the remaining branches with the lines frozen.
module pfb_commutator_seq
    import pfb_pkg::*;
#(
    parameter int FFT_LEN = DEF_FFT_LEN,
    parameter int DEC_FAC = DEF_DEC_FAC,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IDXW    = $clog2(FFT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dl_en,
    output logic [WIDTH-1:0] dl_din,
    output logic [IDXW-1:0]  branch,
    output logic             br_valid,
    output logic             sof,
    output logic             eof,
    output logic [IDXW-1:0]  shift_ofs
);

    localparam logic [IDXW-1:0] LAST_LD = IDXW'(DEC_FAC - 1);
    localparam logic [IDXW-1:0] LAST_BR = IDXW'(FFT_LEN - 1);
    localparam logic [IDXW-1:0] STEP    = IDXW'(DEC_FAC);

    pfb_state_t      state, state_nxt;
    logic [IDXW-1:0] bc;
    logic [IDXW-1:0] acc;
    logic            hs, qual, frame_end;

    // Sample port is open only while loading; state is itself a register.
    assign s_ready = (state == LOAD);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus per-cycle qualifiers (handshake, branch cycle, frame end).
    always_comb begin
        state_nxt = state;
        hs        = 1'b0;
        qual      = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (run)
                    state_nxt = LOAD;
            end
            LOAD: begin
                hs   = s_valid;
                qual = s_valid;
                if (s_valid && bc == LAST_LD)
                    state_nxt = REPLAY;
            end
            REPLAY: begin
                qual = 1'b1;
                if (bc == LAST_BR) begin
                    frame_end = 1'b1;
                    state_nxt = run ? LOAD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Branch counter: advances on every branch cycle, wraps at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bc <= '0;
        else if (frame_end)
            bc <= '0;
        else if (qual)
            bc <= bc + 1'b1;
    end

    // Offset accumulator steps by DEC_FAC mod FFT_LEN at each frame end.
    pfb_mod_acc #(
        .W   (IDXW),
        .MOD (FFT_LEN)
    ) u_ofs_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (frame_end),
        .step (STEP),
        .acc  (acc)
    );

    // Registered outputs, one cycle behind the qualifying cycle. shift_ofs is
    // latched at branch 0 so it stays constant through the frame's eof cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_en     <= 1'b0;
            dl_din    <= '0;
            branch    <= '0;
            br_valid  <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            shift_ofs <= '0;
        end else begin
            dl_en    <= hs;
            br_valid <= qual;
            sof      <= qual && (bc == '0);
            eof      <= qual && (bc == LAST_BR);
            if (hs)
                dl_din <= s_data;
            if (qual)
                branch <= bc;
            if (qual && bc == '0)
                shift_ofs <= acc;
        end
    end

endmodule

// File: tb/tb_pfb_commutator_seq.sv
module tb_pfb_commutator_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        run_e = 1'b0;
    logic        one = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;

    logic        s_ready, dl_en, br_valid, sof, eof;
    logic [15:0] dl_din;
    logic [2:0]  branch, shift_ofs;

    logic        e1_rdy, e1_dle, e1_brv, e1_sof, e1_eof;
    logic [15:0] e1_din;
    logic [2:0]  e1_br, e1_ofs;
    logic        e7_rdy, e7_dle, e7_brv, e7_sof, e7_eof;
    logic [15:0] e7_din;
    logic [2:0]  e7_br, e7_ofs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pfb_commutator_seq #(.FFT_LEN(8), .DEC_FAC(6), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .run(run), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .dl_en(dl_en), .dl_din(dl_din), .branch(branch),
        .br_valid(br_valid), .sof(sof), .eof(eof), .shift_ofs(shift_ofs));

    pfb_commutator_seq #(.FFT_LEN(8), .DEC_FAC(1), .WIDTH(16)) dut_e1 (
        .clk(clk), .rst(rst), .run(run_e), .s_data(s_data), .s_valid(one),
        .s_ready(e1_rdy), .dl_en(e1_dle), .dl_din(e1_din), .branch(e1_br),
        .br_valid(e1_brv), .sof(e1_sof), .eof(e1_eof), .shift_ofs(e1_ofs));

    pfb_commutator_seq #(.FFT_LEN(8), .DEC_FAC(7), .WIDTH(16)) dut_e7 (
        .clk(clk), .rst(rst), .run(run_e), .s_data(s_data), .s_valid(one),
        .s_ready(e7_rdy), .dl_en(e7_dle), .dl_din(e7_din), .branch(e7_br),
        .br_valid(e7_brv), .sof(e7_sof), .eof(e7_eof), .shift_ofs(e7_ofs));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle; the sample source moves to the next value on a handshake.
    task automatic cyc_feed();
        logic hs_p;
        hs_p = s_valid && s_ready;
        cyc();
        if (hs_p) s_data = s_data + 16'd1;
    endtask

    // Bounded wait: 0 = sof, 1 = eof, 2 = branch 6 visible.
    task automatic wait_for(input int what, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc_feed();
            case (what)
                0: hit = sof;
                1: hit = eof;
                default: hit = br_valid && branch == 3'd6;
            endcase
        end
        if (!hit) chk(nm, 0, 1);
    endtask

    // ---------------- scoreboard for dl_din ----------------
    logic [15:0] sb[$];
    always @(posedge clk) begin
        if (rst) sb.delete();
        else if (s_valid && s_ready) sb.push_back(s_data);
    end

    // ---------------- frame monitor (main DUT) ----------------
    logic [2:0] ofs_q[$];
    bit         in_fr = 1'b0;
    int         fr_bv, fr_dl;
    logic [2:0] fr_ofs, last_br;
    always @(negedge clk) begin
        if (rst) begin
            in_fr = 1'b0;
        end else begin
            chk("sof_align", sof, br_valid && branch == 3'd0);
            chk("eof_align", eof, br_valid && branch == 3'd7);
            if (dl_en) begin
                chk("dlen_implies_brv", br_valid, 1);
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else chk("dl_din_sb", dl_din, sb.pop_front());
            end
            if (br_valid) begin
                if (sof) begin
                    in_fr = 1'b1; fr_bv = 1; fr_dl = dl_en ? 1 : 0;
                    fr_ofs = shift_ofs;
                    ofs_q.push_back(shift_ofs);
                end else if (in_fr) begin
                    chk("branch_step", branch, 3'(last_br + 3'd1));
                    chk("ofs_stable", shift_ofs, fr_ofs);
                    fr_bv++;
                    if (dl_en) fr_dl++;
                end
                last_br = branch;
                if (eof && in_fr) begin
                    chk("frame_brv_cnt", fr_bv, 8);
                    chk("frame_dlen_cnt", fr_dl, 6);
                    in_fr = 1'b0;
                end
            end
        end
    end

    // ---------------- edge-parameter monitors ----------------
    int         e1_cnt = 0, e7_cnt = 0;
    int         e1_cnt_q[$], e7_cnt_q[$];
    logic [2:0] e1_ofs_q[$], e7_ofs_q[$];
    always @(negedge clk) begin
        if (rst) begin
            e1_cnt = 0; e7_cnt = 0;
        end else begin
            if (e1_brv && e1_sof) begin e1_ofs_q.push_back(e1_ofs); e1_cnt = 0; end
            if (e1_dle) e1_cnt++;
            if (e1_brv && e1_eof) e1_cnt_q.push_back(e1_cnt);
            if (e7_brv && e7_sof) begin e7_ofs_q.push_back(e7_ofs); e7_cnt = 0; end
            if (e7_dle) e7_cnt++;
            if (e7_brv && e7_eof) e7_cnt_q.push_back(e7_cnt);
        end
    end

    typedef struct {
        logic        run;
        logic        sv;
        logic [15:0] data;
        logic [26:0] exp;   // {s_ready, dl_en, dl_din, br_valid, branch, sof, eof, shift_ofs}
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                                input logic srdy, input logic dle, input logic [15:0] din,
                                input logic brv, input logic [2:0] br, input logic so,
                                input logic eo, input logic [2:0] ofs);
        vec_t t;
        t.run = r; t.sv = v; t.data = d;
        t.exp = {srdy, dle, din, brv, br, so, eo, ofs};
        return t;
    endfunction

    vec_t vecs[10];
    logic [2:0] exp_ofs[5];
    logic [2:0] e7_exp[4];

    initial begin
        // Frame 1 cycle by cycle after leaving IDLE, plus first cycle of frame 2.
        vecs[0] = mk(1, 1, 16'd1, 1, 0, 16'd0, 0, 3'd0, 0, 0, 3'd0);
        vecs[1] = mk(1, 1, 16'd1, 1, 1, 16'd1, 1, 3'd0, 1, 0, 3'd0);
        vecs[2] = mk(1, 1, 16'd2, 1, 1, 16'd2, 1, 3'd1, 0, 0, 3'd0);
        vecs[3] = mk(1, 1, 16'd3, 1, 1, 16'd3, 1, 3'd2, 0, 0, 3'd0);
        vecs[4] = mk(1, 1, 16'd4, 1, 1, 16'd4, 1, 3'd3, 0, 0, 3'd0);
        vecs[5] = mk(1, 1, 16'd5, 1, 1, 16'd5, 1, 3'd4, 0, 0, 3'd0);
        vecs[6] = mk(1, 1, 16'd6, 0, 1, 16'd6, 1, 3'd5, 0, 0, 3'd0);
        vecs[7] = mk(1, 1, 16'd7, 0, 0, 16'd6, 1, 3'd6, 0, 0, 3'd0);
        vecs[8] = mk(1, 1, 16'd7, 1, 0, 16'd6, 1, 3'd7, 0, 1, 3'd0);
        vecs[9] = mk(1, 1, 16'd7, 1, 1, 16'd7, 1, 3'd0, 1, 0, 3'd6);
        exp_ofs = '{3'd0, 3'd6, 3'd4, 3'd2, 3'd0};
        e7_exp  = '{3'd0, 3'd7, 3'd6, 3'd5};

        // Reset state
        cyc();
        chk("reset_outputs", {s_ready, dl_en, dl_din, br_valid, branch, sof, eof, shift_ofs}, 0);
        cyc();
        rst = 1'b0;
        ofs_q.delete();
        cyc();
        chk("idle_no_run", {s_ready, br_valid}, 0);

        // Test 1: table-driven first frame
        for (int i = 0; i < 10; i++) begin
            run = vecs[i].run; s_valid = vecs[i].sv; s_data = vecs[i].data;
            cyc();
            chk($sformatf("vec%0d", i),
                {s_ready, dl_en, dl_din, br_valid, branch, sof, eof, shift_ofs}, vecs[i].exp);
        end

        // Test 2: offsets over 5 continuous frames
        s_data = 16'd8;
        for (int i = 0; i < 60 && ofs_q.size() < 5; i++) cyc_feed();
        if (ofs_q.size() < 5) chk("t2_frames", ofs_q.size(), 5);
        else for (int i = 0; i < 5; i++) chk($sformatf("t2_ofs%0d", i), ofs_q[i], exp_ofs[i]);

        // Test 3: 4-cycle stall at the 3rd sample of a fresh frame
        rst = 1'b1; run = 1'b0;
        cyc(); cyc();
        chk("t3_in_reset", {s_ready, br_valid, shift_ofs}, 0);
        rst = 1'b0; s_data = 16'd1; s_valid = 1'b1; run = 1'b1;
        wait_for(0, "t3_sof_timeout");
        chk("t3_first", {branch, dl_din}, {3'd0, 16'd1});
        cyc_feed();
        chk("t3_br1", {br_valid, branch, dl_din}, {1'b1, 3'd1, 16'd2});
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_feed();
            chk($sformatf("t3_gap%0d", i), {br_valid, dl_en}, 0);
        end
        s_valid = 1'b1;
        cyc_feed();
        chk("t3_resume", {br_valid, dl_en, branch, dl_din}, {1'b1, 1'b1, 3'd2, 16'd3});

        // Test 4: drop run at branch 3, frame completes, then IDLE
        cyc_feed();
        chk("t4_br3", branch, 3'd3);
        run = 1'b0;
        wait_for(1, "t4_eof_timeout");
        chk("t4_eof_br", branch, 3'd7);
        chk("t4_idle_now", s_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc_feed();
            chk($sformatf("t4_idle%0d", i), {s_ready, br_valid, dl_en}, 0);
        end
        run = 1'b1;
        wait_for(0, "t4_sof_timeout");
        chk("t4_reentry_ofs", shift_ofs, 3'd6);

        // Test 5: asynchronous reset mid-REPLAY
        wait_for(2, "t5_br6_timeout");
        #2 rst = 1'b1;
        #1;
        chk("t5_async_zero", {s_ready, dl_en, dl_din, br_valid, branch, sof, eof, shift_ofs}, 0);
        @(posedge clk); #1;
        rst = 1'b0; s_data = 16'd1; s_valid = 1'b1; run = 1'b1;
        wait_for(0, "t5_sof_timeout");
        chk("t5_first", {branch, sof, shift_ofs, dl_din}, {3'd0, 1'b1, 3'd0, 16'd1});

        // Test 6: DEC_FAC = 1 and DEC_FAC = FFT_LEN-1
        rst = 1'b1; run = 1'b0;
        cyc(); cyc();
        e1_cnt_q.delete(); e7_cnt_q.delete(); e1_ofs_q.delete(); e7_ofs_q.delete();
        rst = 1'b0; run_e = 1'b1;
        for (int i = 0; i < 40; i++) cyc();
        run_e = 1'b0;
        if (e1_cnt_q.size() < 4 || e7_cnt_q.size() < 4 || e1_ofs_q.size() < 4 || e7_ofs_q.size() < 4)
            chk("t6_frames", 0, 1);
        else begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t6_e1_dlen%0d", i), e1_cnt_q[i], 1);
                chk($sformatf("t6_e7_dlen%0d", i), e7_cnt_q[i], 7);
                chk($sformatf("t6_e1_ofs%0d", i), e1_ofs_q[i], 3'(i));
                chk($sformatf("t6_e7_ofs%0d", i), e7_ofs_q[i], e7_exp[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pfb_commutator_seq.md
Name: pfb_commutator_seq

Overview:
- Sequencing controller for the oversampled polyphase filter front end.
- Accepts a valid/ready sample stream and produces the write enable and data for the branch delay buffers. It also produces the branch index, frame markers and the phase-rotation offset.
- Per output frame of FFT_LEN branch cycles, it admits DEC_FAC new samples, then replays FFT_LEN-DEC_FAC cycles with the delay lines frozen.
- Sits between the ADC sample interface and the delay-buffer/FIR-tap array.

Parameters:
- FFT_LEN, 64, polyphase branches per frame (P); power of two, ≥4.
- DEC_FAC, 48, new samples per frame (M); 1 ≤ DEC_FAC < FFT_LEN.
- WIDTH, 16, sample width.
- IDXW, $clog2(FFT_LEN), width of branch index and offset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; start/continue framing.
- s_data  in  WIDTH  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sample accepted when s_valid&&s_ready.
- dl_en  out  1  delay-buffer advance enable.
- dl_din  out  WIDTH  sample to delay buffers, aligned with dl_en.
- branch  out  IDXW  current branch index.
- br_valid  out  1  branch cycle valid for the FIR/FFT datapath.
- sof  out  1  first branch cycle of a frame.
- eof  out  1  last branch cycle of a frame.
- shift_ofs  out  IDXW  phase-rotation offset for the current frame.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All counters 0.
  - Outputs: s_ready=0, dl_en=0, dl_din=0, branch=0, br_valid=0, sof=0, eof=0, shift_ofs=0.
- States: IDLE, LOAD, REPLAY.
- IDLE:
  - s_ready=0; no outputs pulse.
  - Moves to LOAD on the clock edge where run=1.
- LOAD:
  - s_ready=1.
  - On a handshake, the branch counter bc increments.
  - If s_valid=0, bc holds and a stall bubble results (br_valid=0 next cycle).
  - After the handshake with bc=DEC_FAC-1, move to REPLAY.
- REPLAY:
  - s_ready=0; bc increments every cycle (no stall).
  - After the cycle with bc=FFT_LEN-1: bc returns to 0 and shift_ofs updates.
  - Next state is LOAD if run=1, else IDLE.
- Output registration: all outputs are registered with a latency of 1 cycle after the qualifying cycle.
  - LOAD handshake → next cycle: dl_en=1, dl_din=s_data, br_valid=1, branch=bc.
  - REPLAY cycle → next cycle: dl_en=0, dl_din holds its last value, br_valid=1, branch=bc.
  - sof=1 with branch 0; eof=1 with branch FFT_LEN-1.
  - dl_en=0 and br_valid=0 on every non-qualifying cycle.
- Offset update:
  - shift_ofs is constant across a frame.
  - At frame end: shift_ofs ← (shift_ofs+DEC_FAC ≥ FFT_LEN) ? shift_ofs+DEC_FAC-FFT_LEN : shift_ofs+DEC_FAC.
  - Computed with an IDXW+1-bit sum; no divider.
  - The new value is visible together with the next frame's sof.
- run deasserted mid-frame: the current frame completes (LOAD then REPLAY), then the block goes to IDLE. bc=0 and shift_ofs is retained.
- Re-entry after IDLE: continues with the retained shift_ofs. Only rst clears shift_ofs.
- Rst asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- Simultaneous events:
  - A last-LOAD handshake with run=0 still enters REPLAY.
  - The REPLAY end-cycle samples run for the next-state decision.
- Counts per frame: exactly DEC_FAC dl_en pulses and exactly FFT_LEN br_valid pulses per frame, branch ascending 0..FFT_LEN-1.

Decomposition:
- Package pfb_pkg:
  - typedef enum for states {IDLE, LOAD, REPLAY}.
  - Default constants FFT_LEN, DEC_FAC, WIDTH.
  - Function for the modular offset step.
- One sub-module, pfb_mod_acc: a parameterised modulo-P accumulator (step, en, clr) used for shift_ofs. Reusable for the output phase-correction stage.

Test Plan (FFT_LEN=8, DEC_FAC=6, WIDTH=16):
1. Reset then run=1, s_valid held 1, data 1,2,3… → per frame:
   - dl_en high 6 cycles with dl_din 1..6, then low 2 cycles.
   - branch 0..7, sof at branch 0, eof at branch 7.
   - s_ready low for 2 cycles per frame.
2. Continuous run for 5 frames → shift_ofs sequence 0,6,4,2,0, each value stable for the whole frame.
3. s_valid deasserted at the 3rd LOAD sample for 4 cycles → 4-cycle br_valid gap after branch 1. Resumes with branch 2 and dl_din=3; still 8 branches and 6 dl_en pulses in that frame.
4. run dropped at branch 3 → frame finishes through branch 7 with eof, then IDLE with s_ready=0. Re-assert run → next frame has shift_ofs=6.
5. rst pulsed asynchronously mid-REPLAY (between clock edges) → outputs zero immediately; after release with run=1, first frame has shift_ofs=0, branch=0, sof=1.
6. Edge parameters: DEC_FAC=1 and DEC_FAC=FFT_LEN-1 → 1 or 7 dl_en per frame respectively. Offsets for DEC_FAC=7: 0,7,6,5…
